// File: rtl/s2_s18_stream_ctrl_if.sv
// Stream-side bundle of the symbol-in / word-out elastic buffer.
// Latency: none; pure signal grouping.
// Backpressure: wr_ready stalls the symbol producer; rd_ready stalls word delivery.
interface s2_s18_stream_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [10:0] level;
    logic        afull;

    // master: the surrounding logic that feeds symbols and consumes words
    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, level, afull
    );

    // slave: the buffer controller itself
    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, level, afull
    );
endinterface

// File: rtl/s2_s18_stream_ctrl.sv
// Elastic buffer controller: 2-bit symbols into an external 2/18-bit asymmetric RAM, 16-bit words out.
// Latency: last symbol of a word accepted in cycle n -> RAM read in n+1 -> rd_valid in n+3.
// Backpressure: wr_ready drops at 1024 buffered words; a stalled reader leaves at most 2 words in the skid.
module s2_s18_stream_ctrl #(
    parameter int unsigned AFULL_LEVEL = 1008
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    s2_s18_stream_ctrl_if.slave        strm,
    output logic [12:0]                ram_addra,
    output logic [1:0]                 ram_dia,
    output logic                       ram_ena,
    output logic                       ram_wea,
    output logic                       ram_ssra,
    output logic [9:0]                 ram_addrb,
    output logic                       ram_enb,
    output logic                       ram_web,
    output logic                       ram_ssrb,
    output logic [15:0]                ram_dib,
    output logic [1:0]                 ram_dipb,
    input  logic [15:0]                ram_dob
);

    // Pointers carry one wrap bit above the 10-bit word address so full and empty differ.
    logic [10:0] wr_ptr;
    logic [10:0] rd_ptr;
    logic [10:0] level;
    logic [2:0]  sym_idx;
    logic        init_done;

    // Skid state: held words, one read in flight, head index of the 2-entry store.
    logic [1:0]  held;
    logic        inflight;
    logic        head;
    logic        tail;
    logic [15:0] skid [2];

    logic        accept;
    logic        pop;
    logic        issue;
    logic [2:0]  occ_after;

    assign level      = wr_ptr - rd_ptr;
    assign strm.level = level;
    assign strm.afull = (32'(level) >= AFULL_LEVEL);

    // A partially filled word already owns slot wr_ptr, so full is judged on whole words.
    assign strm.wr_ready = (level != 11'd1024) && !flush && init_done;
    assign accept        = strm.wr_valid && strm.wr_ready;

    assign strm.rd_valid = (held != 2'd0);
    assign strm.rd_data  = skid[head];
    assign pop           = strm.rd_valid && strm.rd_ready;

    // Only issue a read if the word it returns is guaranteed a skid slot after this edge.
    assign occ_after = {1'b0, held} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (wr_ptr != rd_ptr) && (occ_after < 3'd2) && !flush;

    // With held==2 a push only happens alongside a pop, so head reuses the slot being vacated.
    assign tail = head ^ held[0];

    assign ram_ena   = accept;
    assign ram_wea   = accept;
    assign ram_addra = {wr_ptr[9:0], sym_idx};
    assign ram_dia   = strm.wr_data;
    assign ram_ssra  = 1'b0;

    assign ram_enb   = issue;
    assign ram_addrb = rd_ptr[9:0];
    assign ram_web   = 1'b0;
    assign ram_ssrb  = 1'b0;
    assign ram_dib   = 16'd0;
    assign ram_dipb  = 2'd0;

    // Write side opens on the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Pointer, symbol index and skid occupancy tracking; flush returns to the reset image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sym_idx  <= '0;
            held     <= '0;
            inflight <= 1'b0;
            head     <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sym_idx  <= '0;
            held     <= '0;
            inflight <= 1'b0;
            head     <= 1'b0;
        end else begin
            if (accept) begin
                sym_idx <= sym_idx + 3'd1;
                if (sym_idx == 3'd7) begin
                    wr_ptr <= wr_ptr + 11'd1;
                end
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 11'd1;
            end
            inflight <= issue;
            if (pop) begin
                head <= ~head;
            end
            held <= held + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Capture the RAM word on the edge after its read was issued, unless it is being flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid[0] <= '0;
            skid[1] <= '0;
        end else if (inflight && !flush) begin
            skid[tail] <= ram_dob;
        end
    end

endmodule
